// File: rtl/mb_adc_link.sv
// rtl/mb_adc_link.sv - UART sample-request link to the motherboard ADC frame source
// Optional trailing checksum byte is verified when MB_LINK_CHECKSUM_EN is defined.
module mb_adc_link #(
    parameter int CLKS_PER_BIT   = 20,
    parameter int NUM_CH         = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 enable,
    input  logic                 trigger,
    output logic                 tx,
    input  logic                 rx,
    output logic [16*NUM_CH-1:0] adc_data,
    output logic                 data_valid,
    output logic                 busy,
    output logic [15:0]          good_frames,
    output logic [15:0]          bad_frames,
    output logic [15:0]          timeouts
);
`ifdef MB_LINK_CHECKSUM_EN
    localparam int FRAME_LEN = 2 + 2*NUM_CH;
`else
    localparam int FRAME_LEN = 1 + 2*NUM_CH;
`endif
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);
    localparam logic [7:0]    REQ_BYTE = 8'hA5;
    localparam logic [7:0]    HDR_BYTE = 8'h90;

    typedef enum logic [1:0] {IDLE, TX_REQ, RX_FRAME, CHECK} state_t;

    state_t              state;
    logic [CW-1:0]       tx_cnt;
    logic [3:0]          tx_bit;
    logic [7:0]          tx_shift;
    logic [TW-1:0]       to_cnt;
    logic [IW-1:0]       rx_idx;
    logic [16*NUM_CH-1:0] stage;
`ifdef MB_LINK_CHECKSUM_EN
    logic [7:0]          sum;
    logic [7:0]          chk;
`endif

    logic          rx_meta, rx_sync, rx_prev;
    logic          rx_active;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_done;
    logic          rx_ferr;

    // Byte completion is visible in the stop-bit sample cycle so the frame FSM reacts without extra delay
    assign rx_done = rx_active && (rx_bit == 4'd9) && (rx_cnt == BIT_MID);
    assign rx_ferr = !rx_sync;
    assign busy    = (state != IDLE);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rx_active <= 1'b0;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (!rx_active) begin
                if (rx_prev && !rx_sync) begin
                    rx_active <= 1'b1;
                    rx_cnt    <= CW'(1);
                    rx_bit    <= '0;
                end
            end else begin
                rx_cnt <= (rx_cnt == BIT_LAST) ? '0 : rx_cnt + CW'(1);
                if (rx_cnt == BIT_LAST)
                    rx_bit <= rx_bit + 4'd1;
                if (rx_cnt == BIT_MID) begin
                    // A start bit that is high again at mid-bit was a glitch
                    if (rx_bit == 4'd0) begin
                        if (rx_sync)
                            rx_active <= 1'b0;
                    end else if (rx_bit == 4'd9) begin
                        rx_active <= 1'b0;
                    end else begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= IDLE;
            tx          <= 1'b1;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            to_cnt      <= '0;
            rx_idx      <= '0;
            stage       <= '0;
            adc_data    <= '0;
            data_valid  <= 1'b0;
            good_frames <= '0;
            bad_frames  <= '0;
            timeouts    <= '0;
`ifdef MB_LINK_CHECKSUM_EN
            sum         <= '0;
            chk         <= '0;
`endif
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger && enable) begin
                        state    <= TX_REQ;
                        tx       <= 1'b0;
                        tx_shift <= REQ_BYTE;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                    end
                end
                TX_REQ: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            state  <= RX_FRAME;
                            to_cnt <= '0;
                            rx_idx <= '0;
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                            if (tx_bit == 4'd8) begin
                                tx <= 1'b1;
                            end else begin
                                tx       <= tx_shift[0];
                                tx_shift <= {1'b0, tx_shift[7:1]};
                            end
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                RX_FRAME: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (to_cnt == TO_LAST) begin
                        timeouts <= timeouts + 16'd1;
                        state    <= IDLE;
                    end else if (rx_done) begin
                        if (rx_ferr || ((rx_idx == '0) && (rx_shift != HDR_BYTE))) begin
                            bad_frames <= bad_frames + 16'd1;
                            state      <= IDLE;
                        end else begin
                            rx_idx <= rx_idx + IW'(1);
                            // Sample bytes arrive MSB first; channel 0 lands in the low 16 bits
                            for (int b = 0; b < 2*NUM_CH; b++)
                                if (rx_idx == IW'(b + 1))
                                    stage[(b/2)*16 + ((b%2 == 0) ? 8 : 0) +: 8] <= rx_shift;
`ifdef MB_LINK_CHECKSUM_EN
                            if (rx_idx == IDX_LAST)
                                chk <= rx_shift;
                            else if (rx_idx == '0)
                                sum <= rx_shift;
                            else
                                sum <= sum + rx_shift;
`endif
                            if (rx_idx == IDX_LAST)
                                state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    state <= IDLE;
`ifdef MB_LINK_CHECKSUM_EN
                    if (sum == chk) begin
                        adc_data    <= stage;
                        data_valid  <= 1'b1;
                        good_frames <= good_frames + 16'd1;
                    end else begin
                        bad_frames  <= bad_frames + 16'd1;
                    end
`else
                    adc_data    <= stage;
                    data_valid  <= 1'b1;
                    good_frames <= good_frames + 16'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
